// File: rtl/shuffle_writeback.sv
// Serialises four-lane result beats into single-word feature-map RAM writes at channel-shuffled addresses.
// Latency: beat accepted at T drives lanes 0..3 on wr_* at T+1..T+4; done at T+5 after the last beat.
// Backpressure: in_ready only in ACCEPT or on lane 3 of a non-final beat, so at most 1 beat per 4 cycles.
module shuffle_writeback #(
  parameter int ADDR_W = 16,
  parameter int CH_W   = 8,
  parameter int POS_W  = 12
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   cfg_start,
  input  logic [ADDR_W-1:0]      cfg_base,
  input  logic [CH_W-1:0]        cfg_channels,
  input  logic [POS_W-1:0]       cfg_positions,
  input  logic [1:0]             cfg_group_log2,
  input  logic                   cfg_shuffle_en,
  input  logic                   in_valid,
  input  logic [3:0][15:0]       in_data,
  output logic                   in_ready,
  output logic                   wr_en,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic [15:0]            wr_data,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int PW = CH_W + POS_W;

  typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_WRITE, S_DONE} state_t;

  state_t              r_state, w_state_nxt;

  // Latched run configuration
  logic [ADDR_W-1:0]   r_base;
  logic [CH_W-1:0]     r_chan;
  logic [POS_W-1:0]    r_pos;
  logic [1:0]          r_lg;
  logic                r_shuf;

  // Beat holding register and walk counters. Position counters step to the
  // next beat as lane 3 is issued, so an accept on lane 3 already sees them.
  logic [3:0][15:0]    r_hold;
  logic [1:0]          r_lane;
  logic [POS_W-1:0]    r_p;
  logic [CH_W-1:0]     r_c0;
  logic [CH_W-1:0]     r_k0;
  logic [CH_W-1:0]     r_gi0;
  logic                r_last;

  logic                r_err;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [15:0]         r_wr_data;

  logic [CH_W-1:0]     w_grp_mask;
  logic                w_cfg_ok;
  logic                w_start;
  logic                w_accept;
  logic                w_emit;
  logic [1:0]          w_lane;
  logic [15:0]         w_data;
  logic [CH_W-1:0]     w_cg;
  logic [CH_W-1:0]     w_cp;
  logic [PW-1:0]       w_prod;
  logic [ADDR_W-1:0]   w_addr;
  logic                w_p_last;

  // Config check: non-zero sizes, legal group count, C a multiple of 4*g
  always_comb begin
    w_grp_mask = CH_W'(3);
    case (cfg_group_log2)
      2'd1:    w_grp_mask = CH_W'(7);
      2'd2:    w_grp_mask = CH_W'(15);
      default: w_grp_mask = CH_W'(3);
    endcase
    w_cfg_ok = (cfg_channels != '0) && (cfg_positions != '0) &&
               (cfg_group_log2 != 2'd3) && ((cfg_channels & w_grp_mask) == '0);
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RST_N) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode plus accept/emit strobes and in_ready
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_accept    = 1'b0;
    w_emit      = 1'b0;
    in_ready    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cfg_start && w_cfg_ok) begin
          w_start     = 1'b1;
          w_state_nxt = S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (r_lane != 2'd3) begin
          w_emit = 1'b1;
        end else if (r_last) begin
          w_state_nxt = S_DONE;
        end else begin
          in_ready = 1'b1;
          if (in_valid) w_accept    = 1'b1;
          else          w_state_nxt = S_ACCEPT;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next write: lane select and shuffled destination address from registered counters
  always_comb begin
    w_lane = w_accept ? 2'd0 : r_lane + 2'd1;
    w_data = w_accept ? in_data[0] : r_hold[w_lane];
    w_cg   = r_chan >> r_lg;
    if (r_shuf) w_cp = ((r_k0 + CH_W'(w_lane)) << r_lg) + r_gi0;
    else        w_cp = r_c0 + CH_W'(w_lane);
    w_prod   = {{POS_W{1'b0}}, w_cp} * {{CH_W{1'b0}}, r_pos};
    w_addr   = r_base + ADDR_W'(w_prod) + ADDR_W'(r_p);
    w_p_last = (r_p == r_pos - POS_W'(1));
  end

  // Datapath: config latch, beat capture, counter walk and registered write port
  always_ff @(posedge CLK) begin
    if (RST_N) begin
      r_base    <= '0;
      r_chan    <= '0;
      r_pos     <= '0;
      r_lg      <= '0;
      r_shuf    <= 1'b0;
      r_hold    <= '0;
      r_lane    <= '0;
      r_p       <= '0;
      r_c0      <= '0;
      r_k0      <= '0;
      r_gi0     <= '0;
      r_last    <= 1'b0;
      r_err     <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_err   <= (r_state == S_IDLE) && cfg_start && !w_cfg_ok;
      r_wr_en <= w_accept || w_emit;
      if (w_accept || w_emit) begin
        r_wr_addr <= w_addr;
        r_wr_data <= w_data;
        r_lane    <= w_lane;
      end
      if (w_accept) r_hold <= in_data;
      if (w_start) begin
        r_base <= cfg_base;
        r_chan <= cfg_channels;
        r_pos  <= cfg_positions;
        r_lg   <= cfg_group_log2;
        r_shuf <= cfg_shuffle_en;
        r_lane <= '0;
        r_p    <= '0;
        r_c0   <= '0;
        r_k0   <= '0;
        r_gi0  <= '0;
        r_last <= 1'b0;
      end else if (w_emit && (r_lane == 2'd2)) begin
        // Lane 3 issues now: step to the next beat and flag the final one
        r_last <= w_p_last && ((r_c0 + CH_W'(4)) == r_chan);
        if (w_p_last) begin
          r_p  <= '0;
          r_c0 <= r_c0 + CH_W'(4);
          if ((r_k0 + CH_W'(4)) == w_cg) begin
            r_k0  <= '0;
            r_gi0 <= r_gi0 + CH_W'(1);
          end else begin
            r_k0 <= r_k0 + CH_W'(4);
          end
        end else begin
          r_p <= r_p + POS_W'(1);
        end
      end
    end
  end

  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign busy    = (r_state != S_IDLE);
  assign done    = (r_state == S_DONE);
  assign err     = r_err;

endmodule

// File: tb/tb_shuffle_writeback.sv
// Scoreboard bench: stimulus pushes expected (addr,data) from a div/mod reference model,
// a negedge monitor pops and compares on every wr_en, plus flow-control and status checks.
module tb_shuffle_writeback;
  localparam int ADDR_W = 16;
  localparam int CH_W   = 8;
  localparam int POS_W  = 12;

  logic                CLK = 1'b0;
  logic                RST_N;
  logic                cfg_start;
  logic [ADDR_W-1:0]   cfg_base;
  logic [CH_W-1:0]     cfg_channels;
  logic [POS_W-1:0]    cfg_positions;
  logic [1:0]          cfg_group_log2;
  logic                cfg_shuffle_en;
  logic                in_valid;
  logic [3:0][15:0]    in_data;
  logic                in_ready;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [15:0]         wr_data;
  logic                busy;
  logic                done;
  logic                err;

  shuffle_writeback #(.ADDR_W(ADDR_W), .CH_W(CH_W), .POS_W(POS_W)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .cfg_start(cfg_start), .cfg_base(cfg_base), .cfg_channels(cfg_channels),
    .cfg_positions(cfg_positions), .cfg_group_log2(cfg_group_log2),
    .cfg_shuffle_en(cfg_shuffle_en),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  int cyc = 0;
  int last_wr_cyc = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  int run_len = 0;
  int max_run = 0;
  int rdy_cnt = 0;

  // Current run configuration, used by the reference model
  int t_base, t_C, t_P, t_lg, t_sh;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference: channel c = gi*Cg + k lands at slot k*g + gi when shuffled
  function automatic logic [15:0] exp_addr(input int c, input int p);
    int g, cg, cp;
    g  = 1 << t_lg;
    cg = t_C / g;
    cp = (t_sh != 0) ? ((c % cg) * g + c / cg) : c;
    return 16'((t_base + cp * t_P + p) & 32'hFFFF);
  endfunction

  // Monitor: pop and compare each write, track status activity
  always @(negedge CLK) begin
    logic [31:0] e;
    cyc++;
    if (wr_en === 1'b1) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
      last_wr_cyc = cyc;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, want no write", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        n_vec--;
        check("wr_addr", 32'(wr_addr), {16'h0, e[31:16]});
        check("wr_data", 32'(wr_data), {16'h0, e[15:0]});
      end
    end else begin
      run_len = 0;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (in_ready === 1'b1) rdy_cnt++;
  end

  task automatic send_beat(input logic [63:0] d, input int q, input int p);
    int w;
    w = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge CLK);
    while (in_ready !== 1'b1 && w < 20) begin
      @(negedge CLK);
      w++;
    end
    if (in_ready !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL beat_accept_timeout: q=%0d p=%0d never accepted, want accept", q, p);
    end else begin
      for (int l = 0; l < 4; l++) exp_q.push_back({exp_addr(q * 4 + l, p), d[l*16 +: 16]});
    end
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic start_cfg(input int base, input int C, input int P, input int lg, input int sh);
    cfg_base       = 16'(base);
    cfg_channels   = 8'(C);
    cfg_positions  = 12'(P);
    cfg_group_log2 = 2'(lg);
    cfg_shuffle_en = 1'(sh);
    cfg_start      = 1'b1;
    @(posedge CLK);
    #1;
    cfg_start = 1'b0;
  endtask

  task automatic run_cfg(input int base, input int C, input int P, input int lg, input int sh,
                         input int max_gap, input bit bp, input bit seq, input bit stream);
    int w, gap, bi;
    logic [63:0] d;
    t_base = base; t_C = C; t_P = P; t_lg = lg; t_sh = sh;
    done_cnt = 0;
    start_cfg(base, C, P, lg, sh);
    @(negedge CLK);
    check("busy_after_start", 32'(busy), 1);
    @(posedge CLK);
    #1;
    rdy_cnt = 0;
    max_run = 0;
    for (int q = 0; q < C / 4; q++) begin
      for (int p = 0; p < P; p++) begin
        bi = q * P + p;
        if (seq) d = {16'(bi * 4 + 4), 16'(bi * 4 + 3), 16'(bi * 4 + 2), 16'(bi * 4 + 1)};
        else     d = {$urandom, $urandom};
        send_beat(d, q, p);
        if (!(q == C / 4 - 1 && p == P - 1)) begin
          if (bp) begin
            repeat (4) @(negedge CLK);
            repeat (3) begin
              @(negedge CLK);
              check("bp_wr_en_low", 32'(wr_en), 0);
              check("bp_in_ready_high", 32'(in_ready), 1);
            end
            @(posedge CLK);
            #1;
          end else begin
            gap = $urandom_range(0, max_gap);
            if (gap > 0) begin
              repeat (gap) @(posedge CLK);
              #1;
            end
          end
        end
      end
    end
    w = 0;
    while (done !== 1'b1 && w < 40) begin
      @(negedge CLK);
      w++;
    end
    if (done !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout: done never rose, want a pulse");
    end
    @(posedge CLK);
    #1;
    check("done_after_last_wr", 32'(done_cyc - last_wr_cyc), 1);
    check("writes_outstanding", 32'(exp_q.size()), 0);
    check("done_count", 32'(done_cnt), 1);
    if (stream) begin
      check("stream_wr_run", 32'(max_run), 32'(C * P));
      check("stream_ready_cycles", 32'(rdy_cnt), 32'(C * P / 4));
    end
    @(negedge CLK);
    check("busy_after_done", 32'(busy), 0);
    check("done_single", 32'(done), 0);
  endtask

  task automatic bad_cfg(input int C, input int P, input int lg);
    start_cfg(16'h200, C, P, lg, 1);
    @(negedge CLK);
    check("err_pulse", 32'(err), 1);
    check("busy_bad_cfg", 32'(busy), 0);
    @(negedge CLK);
    check("err_clear", 32'(err), 0);
    check("busy_bad_cfg2", 32'(busy), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check(tag, {27'h0, in_ready, wr_en, busy, done, err}, 0);
    check("rst_wr_addr", 32'(wr_addr), 0);
    check("rst_wr_data", 32'(wr_data), 0);
  endtask

  initial begin
    RST_N = 1'b1;
    cfg_start = 1'b0; cfg_base = '0; cfg_channels = '0; cfg_positions = '0;
    cfg_group_log2 = '0; cfg_shuffle_en = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(posedge CLK);
    #1;
    RST_N = 1'b0;
    @(negedge CLK);
    check_idle_outputs("reset_outputs");
    @(posedge CLK);
    #1;

    // Identity, shuffle, streaming and backpressure runs
    run_cfg(16'h100, 4, 2, 0, 0, 0, 1'b0, 1'b1, 1'b0);
    run_cfg(0, 8, 1, 1, 1, 0, 1'b0, 1'b1, 1'b0);
    run_cfg(16'h040, 8, 4, 1, 1, 0, 1'b0, 1'b0, 1'b1);
    run_cfg(16'h100, 4, 2, 0, 0, 0, 1'b1, 1'b1, 1'b0);

    // Rejected configurations
    bad_cfg(6, 1, 0);
    bad_cfg(4, 1, 1);
    bad_cfg(8, 1, 3);
    bad_cfg(4, 0, 0);

    // Abort on the second write of beat 2, then rerun from the start
    t_base = 16'h100; t_C = 4; t_P = 2; t_lg = 0; t_sh = 0;
    start_cfg(16'h100, 4, 2, 0, 0);
    @(posedge CLK);
    #1;
    send_beat(64'h0004_0003_0002_0001, 0, 0);
    send_beat(64'h0008_0007_0006_0005, 0, 1);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    RST_N = 1'b0;
    exp_q.delete();
    @(negedge CLK);
    check_idle_outputs("abort_outputs");
    repeat (3) @(negedge CLK);
    check("abort_no_done", 32'(done), 0);
    @(posedge CLK);
    #1;
    run_cfg(16'h100, 4, 2, 0, 0, 2, 1'b0, 1'b1, 1'b0);

    // Randomised runs, including address wrap from random bases
    for (int r = 0; r < 8; r++) begin
      int lg;
      lg = $urandom_range(0, 2);
      run_cfg($urandom_range(0, 16'hFFFF), 4 * (1 << lg) * $urandom_range(1, 3),
              $urandom_range(1, 4), lg, $urandom_range(0, 1), 3, 1'b0, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
